// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder state encoding and the default cycle
// counts derived from the system clock, so the LED controller and the
// decoder agree on bit timing.
package ws2812_pkg;

   typedef enum logic [2:0] {
      WS_WAIT_GAP = 3'd0,
      WS_IDLE     = 3'd1,
      WS_CAPTURE  = 3'd2,
      WS_FWD      = 3'd3,
      WS_ERROR    = 3'd4
   } ws2812_state_e;

   localparam int unsigned SysClkFreq  = 32'd40_000_000;

   localparam int unsigned T0hNs       = 32'd400;
   localparam int unsigned T1hNs       = 32'd800;
   localparam int unsigned MinHighNs   = 32'd150;
   localparam int unsigned ThresholdNs = 32'd600;
   localparam int unsigned MaxHighNs   = 32'd1500;
   localparam int unsigned ResetNs     = 32'd50_000;

   // Whole MHz keeps the intermediate product inside 32 bits for 50 us.
   function automatic int unsigned ns_to_cycles(input int unsigned ns);
      return (ns * (SysClkFreq / 32'd1_000_000)) / 32'd1000;
   endfunction

   localparam int unsigned DefT0HighCycles    = ns_to_cycles(T0hNs);
   localparam int unsigned DefT1HighCycles    = ns_to_cycles(T1hNs);
   localparam int unsigned DefMinHighCycles   = ns_to_cycles(MinHighNs);
   localparam int unsigned DefThresholdCycles = ns_to_cycles(ThresholdNs);
   localparam int unsigned DefMaxHighCycles   = ns_to_cycles(MaxHighNs);
   localparam int unsigned DefResetCycles     = ns_to_cycles(ResetNs);

endpackage

// File: rtl/ws2812_decoder_pulse_meas.sv
// Input conditioning for the WS2812 decoder: synchronises the serial line,
// measures high and low times and classifies each completed high pulse.
// Classification outputs are combinational strobes valid in the fall cycle;
// the decoder registers everything it drives off-block.
module ws2812_pulse_meas
   import ws2812_pkg::*;
#(
   parameter int unsigned MinHighCycles      = DefMinHighCycles,
   parameter int unsigned BitThresholdCycles = DefThresholdCycles,
   parameter int unsigned MaxHighCycles      = DefMaxHighCycles,
   parameter int unsigned ResetCycles        = DefResetCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic sync_din,
   output logic rise,
   output logic bit_valid,
   output logic bit_val,
   output logic bit_err,
   output logic gap
);

   localparam int unsigned HiW = $clog2(MaxHighCycles + 2);
   localparam int unsigned LoW = $clog2(ResetCycles + 1);

   localparam logic [HiW-1:0] HiMin = HiW'(MinHighCycles);
   localparam logic [HiW-1:0] HiThr = HiW'(BitThresholdCycles);
   localparam logic [HiW-1:0] HiMax = HiW'(MaxHighCycles);
   localparam logic [HiW-1:0] HiSat = HiW'(MaxHighCycles + 1);
   localparam logic [LoW-1:0] LoSat = LoW'(ResetCycles);
   localparam logic [LoW-1:0] LoGap = LoW'(ResetCycles - 1);

   logic           s1_r;
   logic           s2_r;
   logic           s3_r;
   logic [HiW-1:0] hi_cnt_r;
   logic [LoW-1:0] lo_cnt_r;
   logic           rise_s;
   logic           fall_s;
   logic           bit_valid_s;
   logic           bit_val_s;
   logic           bit_err_s;

   assign rise_s = s2_r & ~s3_r;
   assign fall_s = ~s2_r & s3_r;

   // Two-flop synchroniser plus a history flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= din_i;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // High-time counter; the rise cycle itself counts as the first high cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hi_cnt_r <= {HiW{1'b0}};
      end else if (rise_s) begin
         hi_cnt_r <= HiW'(1);
      end else if (s2_r && (hi_cnt_r != HiSat)) begin
         hi_cnt_r <= hi_cnt_r + HiW'(1);
      end else begin
         hi_cnt_r <= hi_cnt_r;
      end
   end

   // Low-time counter, saturating so the gap strobe fires only once.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lo_cnt_r <= {LoW{1'b0}};
      end else if (s2_r) begin
         lo_cnt_r <= {LoW{1'b0}};
      end else if (lo_cnt_r != LoSat) begin
         lo_cnt_r <= lo_cnt_r + LoW'(1);
      end else begin
         lo_cnt_r <= lo_cnt_r;
      end
   end

   // Classify the finished high pulse in the cycle its fall is seen.
   always_comb begin
      bit_valid_s = 1'b0;
      bit_val_s   = 1'b0;
      bit_err_s   = 1'b0;
      if (fall_s) begin
         if ((hi_cnt_r < HiMin) || (hi_cnt_r > HiMax)) begin
            bit_err_s = 1'b1;
         end else begin
            bit_valid_s = 1'b1;
            bit_val_s   = (hi_cnt_r >= HiThr);
         end
      end else begin
         bit_valid_s = 1'b0;
      end
   end

   assign sync_din  = s2_r;
   assign rise      = rise_s;
   assign bit_valid = bit_valid_s;
   assign bit_val   = bit_val_s;
   assign bit_err   = bit_err_s;
   assign gap       = ~s2_r & (lo_cnt_r == LoGap);

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 stream decoder: captures the first 24 bits after each latch gap as a
// GRB word and forwards every later pulse on dout_o, like a physical LED.
module ws2812_decoder
   import ws2812_pkg::*;
#(
   parameter int unsigned MinHighCycles      = DefMinHighCycles,
   parameter int unsigned BitThresholdCycles = DefThresholdCycles,
   parameter int unsigned MaxHighCycles      = DefMaxHighCycles,
   parameter int unsigned ResetCycles        = DefResetCycles
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        din_i,
   output logic        dout_o,
   output logic [23:0] data_o,
   output logic        data_valid_o,
   output logic        frame_end_o,
   output logic        err_o
);

   localparam logic [2:0] StWaitGap = WS_WAIT_GAP;
   localparam logic [2:0] StIdle    = WS_IDLE;
   localparam logic [2:0] StCapture = WS_CAPTURE;
   localparam logic [2:0] StFwd     = WS_FWD;
   localparam logic [2:0] StError   = WS_ERROR;

   if (!((MinHighCycles < BitThresholdCycles) &&
         (BitThresholdCycles <= MaxHighCycles) &&
         (MaxHighCycles < ResetCycles))) begin : g_bad_params
      $error("ws2812_decoder: need MinHigh < Threshold <= MaxHigh < Reset");
   end

   logic        sync_din_s;
   logic        rise_s;
   logic        bit_valid_s;
   logic        bit_val_s;
   logic        bit_err_s;
   logic        gap_s;

   logic [2:0]  state_r;
   logic [4:0]  bit_cnt_r;
   logic [22:0] shreg_r;
   logic [23:0] data_r;
   logic        data_valid_r;
   logic        frame_end_r;
   logic        err_r;
   logic        dout_r;

   logic [2:0]  state_s;
   logic [4:0]  bit_cnt_s;
   logic [22:0] shreg_s;
   logic [23:0] data_s;
   logic        data_valid_s;
   logic        frame_end_s;
   logic        err_s;
   logic        dout_s;

   ws2812_pulse_meas #(
      .MinHighCycles      (MinHighCycles),
      .BitThresholdCycles (BitThresholdCycles),
      .MaxHighCycles      (MaxHighCycles),
      .ResetCycles        (ResetCycles)
   ) u_pulse_meas (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .din_i     (din_i),
      .sync_din  (sync_din_s),
      .rise      (rise_s),
      .bit_valid (bit_valid_s),
      .bit_val   (bit_val_s),
      .bit_err   (bit_err_s),
      .gap       (gap_s)
   );

   // Frame FSM: next state, word assembly and the next value of every output.
   always_comb begin
      state_s      = state_r;
      bit_cnt_s    = bit_cnt_r;
      shreg_s      = shreg_r;
      data_s       = data_r;
      data_valid_s = 1'b0;
      frame_end_s  = 1'b0;
      err_s        = 1'b0;
      dout_s       = 1'b0;
      case (state_r)
         StWaitGap: begin
            // First gap after reset only synchronises; no frame to close.
            if (gap_s) begin
               state_s = StIdle;
            end else begin
               state_s = StWaitGap;
            end
         end
         StIdle: begin
            if (rise_s) begin
               state_s   = StCapture;
               bit_cnt_s = 5'd0;
            end else begin
               state_s = StIdle;
            end
         end
         StCapture: begin
            if (bit_err_s) begin
               // An invalid 24th pulse lands here too, leaving data_o intact.
               err_s   = 1'b1;
               state_s = StError;
            end else if (bit_valid_s) begin
               shreg_s = {shreg_r[21:0], bit_val_s};
               if (bit_cnt_r == 5'd23) begin
                  data_s       = {shreg_r, bit_val_s};
                  data_valid_s = 1'b1;
                  bit_cnt_s    = 5'd0;
                  state_s      = StFwd;
               end else begin
                  bit_cnt_s = bit_cnt_r + 5'd1;
               end
            end else if (gap_s) begin
               // Truncated word: report it and drop the partial bits.
               err_s       = 1'b1;
               frame_end_s = 1'b1;
               bit_cnt_s   = 5'd0;
               state_s     = StIdle;
            end else begin
               state_s = StCapture;
            end
         end
         StFwd: begin
            dout_s = sync_din_s;
            if (gap_s) begin
               frame_end_s = 1'b1;
               state_s     = StIdle;
            end else begin
               state_s = StFwd;
            end
         end
         StError: begin
            if (gap_s) begin
               frame_end_s = 1'b1;
               state_s     = StIdle;
            end else begin
               state_s = StError;
            end
         end
         default: begin
            state_s = StWaitGap;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= StWaitGap;
         bit_cnt_r    <= 5'd0;
         shreg_r      <= 23'd0;
         data_r       <= 24'h0;
         data_valid_r <= 1'b0;
         frame_end_r  <= 1'b0;
         err_r        <= 1'b0;
         dout_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         bit_cnt_r    <= bit_cnt_s;
         shreg_r      <= shreg_s;
         data_r       <= data_s;
         data_valid_r <= data_valid_s;
         frame_end_r  <= frame_end_s;
         err_r        <= err_s;
         dout_r       <= dout_s;
      end
   end

   assign dout_o       = dout_r;
   assign data_o       = data_r;
   assign data_valid_o = data_valid_r;
   assign frame_end_o  = frame_end_r;
   assign err_o        = err_r;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed testbench for ws2812_decoder with default timing parameters.
module tb_ws2812_decoder;

   logic        clk;
   logic        rst_i;
   logic        din_i;
   logic        dout_o;
   logic [23:0] data_o;
   logic        data_valid_o;
   logic        frame_end_o;
   logic        err_o;

   int err_cnt = 0;
   int chk_cnt = 0;

   // monitor state (written only by the monitor process)
   int     valid_cnt = 0;
   int     fe_cnt = 0;
   int     err_pulses = 0;
   int     both_cnt = 0;
   int     dout_hi_cnt = 0;
   longint valid_t = 0;
   longint fe_t = 0;
   logic   dout_prev = 1'b0;
   int     dout_run = 0;
   longint dout_rise_t = 0;
   int     dout_w_q[$];
   longint dout_rise_q[$];

   // driver state (written only by the stimulus process)
   longint fall_t = 0;
   longint din_rise_q[$];
   int     v0, f0, e0, b0, d0;

   ws2812_decoder dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .din_i        (din_i),
      .dout_o       (dout_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .frame_end_o  (frame_end_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count output pulses and measure forwarded pulse widths on the falling edge.
   always @(negedge clk) begin
      if (data_valid_o) begin valid_cnt++; valid_t = $time; end
      if (frame_end_o) begin fe_cnt++; fe_t = $time; end
      if (err_o) err_pulses++;
      if (err_o && frame_end_o) both_cnt++;
      if (dout_o) dout_hi_cnt++;
      if (dout_o && !dout_prev) begin
         dout_rise_t = $time;
         dout_run = 1;
      end else if (dout_o) begin
         dout_run++;
      end else if (dout_prev) begin
         dout_w_q.push_back(dout_run);
         dout_rise_q.push_back(dout_rise_t);
      end
      dout_prev = dout_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      v0 = valid_cnt; f0 = fe_cnt; e0 = err_pulses; b0 = both_cnt; d0 = dout_hi_cnt;
   endtask

   task automatic send_pulse(input int hi, input int lo);
      din_i = 1'b1;
      din_rise_q.push_back($time);
      repeat (hi) @(negedge clk);
      din_i = 1'b0;
      fall_t = $time;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) send_pulse(32, 18);
      else   send_pulse(16, 34);
   endtask

   task automatic send_bits(input logic [23:0] w, input int hi_idx, input int lo_idx);
      for (int i = hi_idx; i >= lo_idx; i--) send_bit(w[i]);
   endtask

   task automatic send_gap();
      din_i = 1'b0;
      repeat (2010) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ob, db;
      logic [23:0] w2;
      din_i = 1'b0;
      rst_i = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rst_data", data_o, 24'h0);
      check_eq("rst_outs", {dout_o, data_valid_o, frame_end_o, err_o}, 4'b0000);
      rst_i = 1'b0;

      // first gap after reset: no frame_end
      snap();
      send_gap();
      check_eq("first_gap_fe", fe_cnt - f0, 0);

      // single word A53CF0
      snap();
      send_bits(24'hA53CF0, 23, 0);
      check_eq("t1_data", data_o, 24'hA53CF0);
      check_eq("t1_valid_cnt", valid_cnt - v0, 1);
      check_eq("t1_valid_lat", 32'(valid_t - fall_t), 30);
      check_eq("t1_dout_idle", dout_hi_cnt - d0, 0);
      send_gap();
      check_eq("t1_fe_cnt", fe_cnt - f0, 1);
      check_eq("t1_fe_lat", 32'(fe_t - fall_t), 20020);
      check_eq("t1_err", err_pulses - e0, 0);

      // two words: first captured, second forwarded
      snap();
      send_bits(24'h123456, 23, 0);
      ob = dout_w_q.size();
      db = din_rise_q.size();
      w2 = 24'hABCDEF;
      send_bits(w2, 23, 0);
      send_gap();
      check_eq("t2_data", data_o, 24'h123456);
      check_eq("t2_valid_cnt", valid_cnt - v0, 1);
      check_eq("t2_fe_cnt", fe_cnt - f0, 1);
      check_eq("t2_fwd_cnt", dout_w_q.size() - ob, 24);
      for (int i = 0; i < 24; i++) begin
         if (dout_w_q.size() > ob + i) begin
            check_eq($sformatf("t2_fwd_w%0d", i), dout_w_q[ob + i], w2[23 - i] ? 32 : 16);
            check_eq($sformatf("t2_fwd_d%0d", i),
                     32'(dout_rise_q[ob + i] - din_rise_q[db + i]), 30);
         end
      end

      // glitch at bit 5
      snap();
      send_bits(24'hFFFFFF, 23, 19);
      send_pulse(4, 30);
      send_bits(24'hFFFFFF, 17, 0);
      send_gap();
      check_eq("t3_err", err_pulses - e0, 1);
      check_eq("t3_valid", valid_cnt - v0, 0);
      check_eq("t3_fe", fe_cnt - f0, 1);
      check_eq("t3_data_kept", data_o, 24'h123456);
      snap();
      send_bits(24'h5A5A5A, 23, 0);
      send_gap();
      check_eq("t3_recover", data_o, 24'h5A5A5A);
      check_eq("t3_rec_valid", valid_cnt - v0, 1);

      // truncated word: 10 bits then gap
      snap();
      send_bits(24'hC3C3C3, 23, 14);
      send_gap();
      check_eq("t4_err", err_pulses - e0, 1);
      check_eq("t4_fe", fe_cnt - f0, 1);
      check_eq("t4_coincide", both_cnt - b0, 1);
      check_eq("t4_valid", valid_cnt - v0, 0);
      check_eq("t4_data_kept", data_o, 24'h5A5A5A);

      // boundary widths 23/24/60 then 21 normal bits
      snap();
      send_pulse(23, 27);
      send_pulse(24, 26);
      send_pulse(60, 18);
      send_bits(24'h0ABCDE, 20, 0);
      check_eq("t5_bounds", data_o, 24'h6ABCDE);
      check_eq("t5_err", err_pulses - e0, 0);
      send_gap();
      snap();
      send_pulse(61, 20);
      send_gap();
      check_eq("t5_61_err", err_pulses - e0, 1);
      check_eq("t5_61_valid", valid_cnt - v0, 0);
      check_eq("t5_61_data", data_o, 24'h6ABCDE);

      // reset in mid-frame
      send_bits(24'h777777, 23, 12);
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      check_eq("t6_rst_data", data_o, 24'h0);
      snap();
      send_bits(24'h777777, 11, 0);
      send_bits(24'h999999, 23, 0);
      send_gap();
      check_eq("t6_no_valid", valid_cnt - v0, 0);
      check_eq("t6_no_fe", fe_cnt - f0, 0);
      send_bits(24'h00FF00, 23, 0);
      send_gap();
      check_eq("t6_data", data_o, 24'h00FF00);
      check_eq("t6_valid", valid_cnt - v0, 1);
      check_eq("t6_fe", fe_cnt - f0, 1);
      check_eq("t6_err", err_pulses - e0, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
